// File: rtl/uart_bus_bridge_pkg.sv
// Shared constants, widths and FSM encoding for the UART-to-bus command bridge.
package uart_bus_bridge_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned BCNT_W = 2;
    localparam int unsigned REM_W  = 3;
    localparam int unsigned LAT_W  = 4;

    localparam logic [BYTE_W-1:0] CMD_WRITE = 8'h57;
    localparam logic [BYTE_W-1:0] CMD_READ  = 8'h52;
    localparam logic [BYTE_W-1:0] RSP_ACK   = 8'h06;
    localparam logic [BYTE_W-1:0] RSP_NAK   = 8'h15;

    localparam logic [REM_W-1:0] REM_ONE  = 3'd1;
    localparam logic [REM_W-1:0] REM_WORD = 3'd4;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        WRITE,
        READ,
        RDWAIT,
        TX_LOAD,
        TX_WAIT
    } state_t;

endpackage

// File: rtl/uart_bus_bridge.sv
// UART-to-bus command bridge: decodes 'W'/'R' frames into single-word bus accesses.
// Optional inter-byte frame timeout enabled by defining UART_BUS_BRIDGE_TIMEOUT_EN.
module uart_bus_bridge
    import uart_bus_bridge_pkg::*;
#(
    parameter int unsigned READ_LATENCY   = 1,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_done,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_start,
    input  logic              tx_done,
    output logic [WORD_W-1:0] address,
    output logic [WORD_W-1:0] WD,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [WORD_W-1:0] RD,
    output logic              busy
);

    if ((READ_LATENCY < 1) || (READ_LATENCY > 15) || (TIMEOUT_CYCLES < 1)) begin : g_bad_param
        $error("uart_bus_bridge: READ_LATENCY must be 1..15 and TIMEOUT_CYCLES nonzero");
    end

    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY - 1);

    state_t              state, state_d;
    logic [BCNT_W-1:0]   byte_cnt, byte_cnt_d;
    logic                is_write, is_write_d;
    logic [WORD_W-1:0]   resp, resp_d;
    logic [REM_W-1:0]    rem, rem_d;
    logic [LAT_W-1:0]    lat_cnt, lat_cnt_d;
    logic [WORD_W-1:0]   address_d, wd_d;
    logic [BYTE_W-1:0]   tx_data_d;
    logic                tx_start_d, mem_write_d, mem_read_d, busy_d;

`ifdef UART_BUS_BRIDGE_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt, to_cnt_d;
`endif

    // State and all registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            byte_cnt  <= '0;
            is_write  <= 1'b0;
            resp      <= '0;
            rem       <= '0;
            lat_cnt   <= '0;
            address   <= '0;
            WD        <= '0;
            tx_data   <= '0;
            tx_start  <= 1'b0;
            mem_write <= 1'b0;
            mem_read  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            byte_cnt  <= byte_cnt_d;
            is_write  <= is_write_d;
            resp      <= resp_d;
            rem       <= rem_d;
            lat_cnt   <= lat_cnt_d;
            address   <= address_d;
            WD        <= wd_d;
            tx_data   <= tx_data_d;
            tx_start  <= tx_start_d;
            mem_write <= mem_write_d;
            mem_read  <= mem_read_d;
            busy      <= busy_d;
        end
    end

`ifdef UART_BUS_BRIDGE_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt_d;
        end
    end
`endif

    // Next-state logic; strobes are registered from the next state so they align with it
    always_comb begin
        state_d    = state;
        byte_cnt_d = byte_cnt;
        is_write_d = is_write;
        resp_d     = resp;
        rem_d      = rem;
        lat_cnt_d  = lat_cnt;
        address_d  = address;
        wd_d       = WD;
        tx_data_d  = tx_data;
`ifdef UART_BUS_BRIDGE_TIMEOUT_EN
        to_cnt_d   = '0;
`endif

        case (state)
            IDLE: begin
                if (rx_done) begin
                    byte_cnt_d = '0;
                    if (rx_data == CMD_WRITE) begin
                        is_write_d = 1'b1;
                        state_d    = ADDR;
                    end else if (rx_data == CMD_READ) begin
                        is_write_d = 1'b0;
                        state_d    = ADDR;
                    end else begin
                        resp_d  = WORD_W'(RSP_NAK);
                        rem_d   = REM_ONE;
                        state_d = TX_LOAD;
                    end
                end
            end
            ADDR: begin
                if (rx_done) begin
                    address_d  = {rx_data, address[WORD_W-1:BYTE_W]};
                    byte_cnt_d = byte_cnt + BCNT_W'(1);
                    if (byte_cnt == '1) begin
                        state_d = is_write ? DATA : READ;
                    end
                end
            end
            DATA: begin
                if (rx_done) begin
                    wd_d       = {rx_data, WD[WORD_W-1:BYTE_W]};
                    byte_cnt_d = byte_cnt + BCNT_W'(1);
                    if (byte_cnt == '1) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                resp_d  = WORD_W'(RSP_ACK);
                rem_d   = REM_ONE;
                state_d = TX_LOAD;
            end
            READ: begin
                lat_cnt_d = '0;
                state_d   = RDWAIT;
            end
            RDWAIT: begin
                if (lat_cnt == LAT_LAST) begin
                    resp_d    = RD;
                    rem_d     = REM_WORD;
                    lat_cnt_d = '0;
                    state_d   = TX_LOAD;
                end else begin
                    lat_cnt_d = lat_cnt + LAT_W'(1);
                end
            end
            TX_LOAD: begin
                state_d = TX_WAIT;
            end
            TX_WAIT: begin
                if (tx_done) begin
                    rem_d = rem - REM_W'(1);
                    if (rem_d != '0) begin
                        resp_d  = resp >> BYTE_W;
                        state_d = TX_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef UART_BUS_BRIDGE_TIMEOUT_EN
        // Silent abort when the host stalls mid-frame; any received byte restarts the count
        if (((state == ADDR) || (state == DATA)) && !rx_done) begin
            if (to_cnt == TO_W'(TIMEOUT_CYCLES)) begin
                state_d = IDLE;
            end else begin
                to_cnt_d = to_cnt + TO_W'(1);
            end
        end
`endif

        tx_start_d  = (state_d == TX_LOAD);
        mem_write_d = (state_d == WRITE);
        mem_read_d  = (state_d == READ);
        busy_d      = (state_d != IDLE);
        if (state_d == TX_LOAD) begin
            tx_data_d = resp_d[BYTE_W-1:0];
        end
    end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Scoreboard bench for uart_bus_bridge: stimulus pushes expected bus accesses and
// response bytes; a monitor pops and compares whenever the DUT strobes an output.
module tb_uart_bus_bridge;
    import uart_bus_bridge_pkg::*;

    localparam int unsigned LAT = 2;
    localparam int unsigned TMO = 50;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_done;
    logic [31:0] address;
    logic [31:0] WD;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] RD;
    logic        busy;

    uart_bus_bridge #(
        .READ_LATENCY  (LAT),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_done  (rx_done),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_done  (tx_done),
        .address  (address),
        .WD       (WD),
        .mem_write(mem_write),
        .mem_read (mem_read),
        .RD       (RD),
        .busy     (busy)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int tx_done_cnt = 0;

    logic [7:0]  exp_tx[$];
    logic [31:0] exp_wr_addr[$];
    logic [31:0] exp_wr_data[$];
    logic [31:0] exp_rd_addr[$];

    logic [31:0] rd_value;
    logic [3:0]  rd_pipe = 4'd0;
    assign RD = rd_pipe[LAT-1] ? rd_value : 32'hBAD0_BAD0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_checks++;
        n_fail++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Responder: RD carries the word only LAT cycles after the mem_read strobe
    initial begin
        logic mr;
        forever begin
            @(negedge clk);
            mr = mem_read;
            @(posedge clk);
            #1;
            rd_pipe = {rd_pipe[2:0], mr};
        end
    end

    // Transmitter model: tx_done three cycles after each accepted tx_start
    initial begin
        logic aborted;
        tx_done = 1'b0;
        forever begin
            @(posedge clk);
            if (tx_start === 1'b1 && !rst) begin
                aborted = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(posedge clk);
                    if (rst) aborted = 1'b1;
                end
                if (!aborted) begin
                    #1 tx_done = 1'b1;
                    @(posedge clk);
                    #1 tx_done = 1'b0;
                    tx_done_cnt++;
                end
            end
        end
    end

    // Monitor: compare every strobe against the scoreboard queues
    initial begin
        logic       tx_pending;
        logic [7:0] tx_held;
        tx_pending = 1'b0;
        tx_held    = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                tx_pending = 1'b0;
            end else begin
                if (tx_pending) check("tx_data_hold", 32'(tx_data), 32'(tx_held));
                if (tx_done) tx_pending = 1'b0;
                if (tx_start) begin
                    check("tx_start_before_done", 32'(tx_pending), 32'd0);
                    if (exp_tx.size() == 0)
                        fail_now("tx_unexpected", $sformatf("got byte 0x%02h, want no transmission", tx_data));
                    else
                        check("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
                    tx_pending = 1'b1;
                    tx_held    = tx_data;
                end
                if (mem_write) begin
                    if (exp_wr_addr.size() == 0) begin
                        fail_now("wr_unexpected", $sformatf("got write 0x%08h, want none", address));
                    end else begin
                        check("wr_address", address, exp_wr_addr.pop_front());
                        check("wr_data", WD, exp_wr_data.pop_front());
                    end
                end
                if (mem_read) begin
                    if (exp_rd_addr.size() == 0)
                        fail_now("rd_unexpected", $sformatf("got read 0x%08h, want none", address));
                    else
                        check("rd_address", address, exp_rd_addr.pop_front());
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk);
        #1;
        rx_done = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [31:0] a,
                              input logic has_data, input logic [31:0] d);
        send_byte(cmd);
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
        if (has_data) for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
    endtask

    task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
        exp_wr_addr.push_back(a);
        exp_wr_data.push_back(d);
        exp_tx.push_back(RSP_ACK);
    endtask

    task automatic expect_read(input logic [31:0] a, input logic [31:0] d);
        exp_rd_addr.push_back(a);
        for (int i = 0; i < 4; i++) exp_tx.push_back(d[8*i +: 8]);
    endtask

    task automatic wait_idle(input string name);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            if (!busy && exp_tx.size() == 0 && exp_wr_addr.size() == 0 && exp_rd_addr.size() == 0)
                done = 1'b1;
        end
        if (!done) begin
            fail_now(name, $sformatf("timed out, busy=%0b tx left=%0d, want idle with all responses seen",
                                     busy, exp_tx.size()));
            exp_tx.delete();
            exp_wr_addr.delete();
            exp_wr_data.delete();
            exp_rd_addr.delete();
        end else begin
            check(name, 32'(busy), 32'd0);
        end
    endtask

    task automatic wait_tx_done(input int target, input string name);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 500 && !done; i++) begin
            @(posedge clk);
            #2;
            if (tx_done_cnt >= target) done = 1'b1;
        end
        if (!done) fail_now(name, $sformatf("tx_done count %0d, want %0d", tx_done_cnt, target));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        check({tag, "_tx_start"}, 32'(tx_start), 32'd0);
        check({tag, "_address"}, address, 32'd0);
        check({tag, "_wd"}, WD, 32'd0);
        check({tag, "_mem_write"}, 32'(mem_write), 32'd0);
        check({tag, "_mem_read"}, 32'(mem_read), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int base;
        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_done  = 1'b0;
        rd_value = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // Write frame with ACK
        expect_write(32'h8000_0010, 32'hDEAD_BEEF);
        send_frame(CMD_WRITE, 32'h8000_0010, 1'b1, 32'hDEAD_BEEF);
        wait_idle("write_done");
        check("write_addr_hold", address, 32'h8000_0010);
        check("write_wd_hold", WD, 32'hDEAD_BEEF);

        // Read frame, four response bytes LSB first
        rd_value = 32'h1234_5678;
        expect_read(32'h8000_0004, 32'h1234_5678);
        send_frame(CMD_READ, 32'h8000_0004, 1'b0, 32'h0);
        wait_idle("read_done");

        // Unknown command: NAK only, then a normal write
        exp_tx.push_back(RSP_NAK);
        send_byte(8'h41);
        wait_idle("nak_done");
        expect_write(32'h0000_0020, 32'h4433_2211);
        send_frame(CMD_WRITE, 32'h0000_0020, 1'b1, 32'h4433_2211);
        wait_idle("write_after_nak");

        // Stalled frame
        send_byte(CMD_WRITE);
        send_byte(8'h01);
        send_byte(8'h02);
        repeat (60) @(posedge clk);
        @(negedge clk);
`ifdef UART_BUS_BRIDGE_TIMEOUT_EN
        check("timeout_idle", 32'(busy), 32'd0);
`else
        check("stall_still_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
`endif
        rd_value = 32'hCAFE_F00D;
        expect_read(32'h0000_0100, 32'hCAFE_F00D);
        send_frame(CMD_READ, 32'h0000_0100, 1'b0, 32'h0);
        wait_idle("read_after_stall");

        // Reset after the second response byte of a read
        rd_value = 32'hA1B2_C3D4;
        expect_read(32'h0000_0008, 32'hA1B2_C3D4);
        base = tx_done_cnt;
        send_frame(CMD_READ, 32'h0000_0008, 1'b0, 32'h0);
        wait_tx_done(base + 2, "reset_wait_two_bytes");
        rst = 1'b1;
        exp_tx.delete();
        @(negedge clk);
        check_all_zero("midreset");
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        expect_write(32'h0000_0044, 32'h1234_5678);
        send_frame(CMD_WRITE, 32'h0000_0044, 1'b1, 32'h1234_5678);
        wait_idle("write_after_reset");

        // Bytes arriving while the response is in flight are ignored
        rd_value = 32'h0BAD_F00D;
        expect_read(32'h0000_000C, 32'h0BAD_F00D);
        base = tx_done_cnt;
        send_frame(CMD_READ, 32'h0000_000C, 1'b0, 32'h0);
        wait_tx_done(base + 1, "inject_wait_first_byte");
        send_byte(CMD_WRITE);
        send_byte(8'h41);
        wait_idle("inject_done");
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("inject_stays_idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_bus_bridge.md
# uart_bus_bridge

UART-to-bus command bridge: the initiator on the memory-mapped bus, driven by a host across the serial link. It consumes received bytes from the UART receiver, decodes framed read/write commands, and issues single-word bus transactions toward `memory_mapped_IO`-style responders. For a read it returns the word through the UART transmitter; for a write it returns an acknowledge byte.

## Interface
- `READ_LATENCY`, 1: cycles from `mem_read` assertion to valid `RD`; legal range is 1–15.
- `TIMEOUT_CYCLES`, 100000: idle cycles allowed between command bytes before the frame is aborted.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `rx_data` in 8: byte from the UART receiver.
- `rx_done` in 1: one-cycle pulse; `rx_data` is valid in this cycle.
- `tx_data` out 8: byte to the UART transmitter; held stable from `tx_start` until `tx_done`.
- `tx_start` out 1: one-cycle pulse that starts transmission of one byte.
- `tx_done` in 1: one-cycle pulse when the transmitter finishes the byte.
- `address` out 32: bus address.
- `WD` out 32: bus write data.
- `mem_write` out 1: one-cycle write strobe.
- `mem_read` out 1: one-cycle read strobe.
- `RD` in 32: bus read data.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- Frame format, all multi-byte fields little-endian:
  - Write: `0x57` ('W'), then 4 address bytes, then 4 data bytes. Response is `0x06` (ACK).
  - Read: `0x52` ('R'), then 4 address bytes. Response is 4 data bytes, LSB first.
  - Any other command byte: response is `0x15` (NAK), then return to IDLE.
- FSM states: IDLE, ADDR, DATA, WRITE, READ, RDWAIT, TX_LOAD, TX_WAIT.
  - IDLE: on `rx_done`, decode the command. 'W' or 'R' goes to ADDR. Anything else loads NAK and goes to TX_LOAD.
  - ADDR: shift in 4 bytes using a 2-bit byte counter. Then 'W' goes to DATA and 'R' goes to READ.
  - DATA: shift in 4 bytes, then go to WRITE.
  - WRITE: assert `mem_write` for one cycle, load ACK, go to TX_LOAD.
  - READ: assert `mem_read` for one cycle, go to RDWAIT.
  - RDWAIT: count `READ_LATENCY` cycles, capture `RD` into a 32-bit response register, set the bytes-remaining count to 4, go to TX_LOAD.
  - TX_LOAD: drive `tx_data`, pulse `tx_start`, go to TX_WAIT.
  - TX_WAIT: on `tx_done`, decrement bytes remaining. If nonzero, shift the response register right by 8 and go to TX_LOAD. Otherwise go to IDLE.
- `address` and `WD` are registers built from the shifted bytes. They hold their values after a transaction until the next frame overwrites them.
- Received bytes are ignored in WRITE, READ, RDWAIT, TX_LOAD and TX_WAIT. The link is half-duplex by protocol.

## Timing
- Reset values: all outputs 0, FSM in IDLE, all counters 0.
- Write: `mem_write` is high in the cycle after the `rx_done` of data byte 3. `address` and `WD` are already stable in that cycle. `tx_start` (ACK) follows 1 cycle later.
- Read: `mem_read` is high in the cycle after the `rx_done` of address byte 3. `RD` is sampled `READ_LATENCY` cycles after `mem_read`. The first `tx_start` follows 1 cycle after sampling.
- `tx_start` and `tx_done` in the same cycle cannot occur: `tx_done` is only honoured in TX_WAIT.
- Reset asserted mid-frame or mid-response: abort immediately, with no strobe and no further `tx_start`.

## Configuration
- Macro `UART_BUS_BRIDGE_TIMEOUT_EN`.
- When defined:
  - A counter runs in ADDR and DATA. It clears on each `rx_done`.
  - When it reaches `TIMEOUT_CYCLES`, the FSM returns to IDLE silently, with no bus strobe and no response.
- When undefined: there is no counter, and the FSM waits indefinitely for the next byte.

## Structure
- Package `uart_bus_bridge_pkg` holds:
  - the command constants CMD_WRITE = 8'h57, CMD_READ = 8'h52, RSP_ACK = 8'h06, RSP_NAK = 8'h15;
  - the FSM state enum.
- Single module, with no sub-modules. The timeout counter is inline under the macro.

## Test plan
- Write frame 57 10 00 00 80 EF BE AD DE → one `mem_write` pulse with `address`=0x80000010 and `WD`=0xDEADBEEF; one `tx_data`=0x06 byte.
- Read frame 52 04 00 00 80 with `RD`=0x12345678 and `READ_LATENCY`=2 → one `mem_read` pulse with `address`=0x80000004; `tx_data` sequence 78 56 34 12, each byte started only after the previous `tx_done`.
- Command byte 0x41 → no bus strobe; one NAK 0x15; then a valid write frame completes normally.
- Macro defined, `TIMEOUT_CYCLES`=50, frame 57 01 02 then 60 idle cycles → no strobe, no transmission, FSM in IDLE; a following read frame succeeds.
- `rst` pulsed after the second response byte of a read → all outputs 0 the next cycle; no further `tx_start`; a new frame is accepted.
- Extra `rx_done` bytes injected during TX_WAIT → ignored; the response sequence is unchanged.
